// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit direction counters
// Zero-latency fetch lookup, trained by resolved conditional branches from EX.
module branch_predictor #(
  parameter  int ENTRIES = 16,
  localparam int INDEX_W = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - INDEX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        branch_predict_hit,
  output logic        branch_prediction,
  output logic [31:0] predicted_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] br_count,
  output logic [31:0] mispredict_count
);

  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [31:0] br_count_q;
  logic [31:0] mispredict_count_q;

  logic [INDEX_W-1:0] if_idx;
  logic [TAG_W-1:0]   if_tag;
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               if_hit;
  logic               upd_hit;

  // Word-aligned PCs: the two low bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, if_pc[1:0], upd_pc[1:0]};

  assign if_idx  = if_pc[INDEX_W+1:2];
  assign if_tag  = if_pc[31:INDEX_W+2];
  assign upd_idx = upd_pc[INDEX_W+1:2];
  assign upd_tag = upd_pc[31:INDEX_W+2];

  assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign branch_predict_hit = if_hit;
  assign branch_prediction  = if_hit & ctr_q[if_idx][1];
  assign predicted_target   = if_hit ? target_q[if_idx] : 32'd0;

  assign br_count         = br_count_q;
  assign mispredict_count = mispredict_count_q;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    if (taken) begin
      return (c == 2'b11) ? c : c + 2'd1;
    end
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_step(ctr_q[upd_idx], upd_taken);
        if (upd_taken) begin
          target_q[upd_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        // Taken miss evicts whatever lives at this index.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q         <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else if (upd_valid) begin
      br_count_q <= br_count_q + 32'd1;
      if (upd_mispredict) begin
        mispredict_count_q <= mispredict_count_q + 32'd1;
      end
    end
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

- Fetch-stage direction and target predictor.
- Built from a direct-mapped branch target buffer (BTB) plus a 2-bit saturating counter per entry.
- Looks up the IF-stage PC and produces the `branch_prediction`, `branch_predict_hit` and `predicted_target` values. These travel down the pipeline and are checked by branch control in EX.
- Trained from the EX-stage resolution of conditional (B-type) branches, and keeps 32-bit branch and mispredict performance counters.

## Interface
Parameters:
- `ENTRIES`, 16, number of BTB entries; power of two, 2..256.
- `INDEX_W`, `$clog2(ENTRIES)`, index width; derived, not overridden.
- `TAG_W`, `30-INDEX_W`, stored tag width; derived.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_pc` in 32: fetch PC being looked up.
- `branch_predict_hit` out 1: valid entry whose tag matches `if_pc`.
- `branch_prediction` out 1: bit 1 of the matched entry's counter. 0 when there is no hit.
- `predicted_target` out 32: stored target of the matched entry. 0 when there is no hit.
- `upd_valid` in 1: EX reports a resolved B-type branch this cycle.
- `upd_pc` in 32: PC of the resolved branch.
- `upd_taken` in 1: actual outcome (`branch_taken_flag`).
- `upd_target` in 32: actual taken target (pc_imm).
- `upd_mispredict` in 1: branch control's `branch_mispredict` for this branch. Qualified by `upd_valid`.
- `br_count` out 32: count of resolved B-type branches.
- `mispredict_count` out 32: count of resolved branches with `upd_mispredict` = 1.

## Operation
Address split (PCs are word-aligned):
- index = pc[INDEX_W+1:2]
- tag = pc[31:INDEX_W+2]
- pc[1:0] is ignored.

Per-entry state:
- `valid` (1 bit), `tag` (TAG_W), `target` (32), `ctr` (2).
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11.

Lookup (combinational from `if_pc` and current state):
- hit = valid[idx] && tag[idx]==tag(if_pc).
- `branch_prediction` = hit & ctr[idx][1].
- `predicted_target` = hit ? target[idx] : 0.

Update, when `upd_valid` = 1. The entry is selected by `upd_pc`:
- **Hit and taken:** ctr increments, saturating at 11. Target is rewritten with `upd_target`.
- **Hit and not taken:** ctr decrements, saturating at 00. Target is unchanged.
- **Miss and taken:** allocate and overwrite whatever is at the index. Set valid=1, tag=tag(upd_pc), target=`upd_target`, ctr=WT (10).
- **Miss and not taken:** no change to the BTB.

Performance counters:
- `br_count` increments by 1 on every `upd_valid`.
- `mispredict_count` increments on `upd_valid` && `upd_mispredict`.
- Both wrap 0xFFFF_FFFF -> 0 with no saturation.

Other rules:
- JAL/JALR are never presented on the update port. The block does not distinguish branch types.
- With `upd_valid` = 0, all other update inputs are don't-care and no state changes.

## Timing
- Lookup latency is 0 cycles; outputs depend combinationally on `if_pc` only.
- An update is visible to lookups from the cycle after the `upd_valid` edge.
- **Same-cycle collision:** a lookup and an update to the same index in the same cycle return the pre-update contents. There is no write-to-read bypass.
- **Reset:**
  - All `valid` = 0, all `ctr` = WNT (01), all `target` = 0, `br_count` = `mispredict_count` = 0.
  - Consequently, during and right after reset: `branch_predict_hit` = 0, `branch_prediction` = 0, `predicted_target` = 0.
- `rst` has priority over a coincident update; that update is discarded.
- Reset asserted mid-run clears state at the next edge. The first post-reset update behaves as on a cold BTB.
- No stall input: EX presents each resolved branch exactly once, with `upd_valid` high for one cycle.

## Test plan
- **Reset, then cold lookup:** hold `rst` 2 cycles, release, then drive `if_pc`=0x0000_0040. Require hit=0, prediction=0, target=0, both counters=0.
- **Allocate on taken miss:** `upd_valid`=1, `upd_pc`=0x40, taken=1, target=0x100, mispredict=1. Next cycle, lookup 0x40 gives hit=1, prediction=1, target=0x100; `br_count`=1, `mispredict_count`=1.
- **Counter saturation walk** on the 0x40 entry:
  - 2 taken updates make ctr=11.
  - A 3rd taken update leaves it at 11.
  - 2 not-taken updates give ctr=01, so prediction=0 while hit remains 1.
  - 2 more not-taken updates leave it at 00.
- **Tag alias** (ENTRIES=16): with 0x40 resident, a taken update at 0x440 (same index 0) replaces the entry. Lookup 0x40 then gives hit=0; lookup 0x440 gives hit=1 with the new target.
- **Collision and no-allocate:**
  - Update 0x80 not-taken on a miss: later lookup of 0x80 gives hit=0, while `br_count` still increments.
  - Same-cycle lookup and taken update on 0x80: the lookup that cycle shows hit=0 and the next cycle shows hit=1.
- **Reset priority and counter wrap:**
  - Assert `rst` together with `upd_valid`: no entry is allocated.
  - Force `br_count` to 0xFFFF_FFFF through a hierarchical deposit, then one update: count becomes 0.
